// File: rtl/serv_lsu_w.sv
// serv_lsu_w: W-bit-per-cycle load/store unit for the serial core.
// Builds the address serially, runs one Wishbone access, then streams load data back.
module serv_lsu_w #(
    parameter int W       = 1,
    parameter int TIMEOUT = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_init,
    input  logic          i_en,
    input  logic          i_cmd,
    input  logic [2:0]    i_funct3,
    input  logic [W-1:0]  i_rs1,
    input  logic [W-1:0]  i_imm,
    input  logic [W-1:0]  i_rs2,
    input  logic          i_trap,
    output logic [W-1:0]  o_rd,
    output logic          o_busy,
    output logic          o_misalign,
    output logic          o_bus_err,
    output logic [31:0]   o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    input  logic          i_wb_err
);

    localparam int N  = 32 / W;
    localparam int CW = $clog2(N);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        BUS  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    logic            first;
    logic            beat;
    logic            last;
    logic            cin;
    logic [W:0]      sum;
    logic [4:0]      bidx;
    logic            is_word;
    logic            is_half;
    logic            misal;
    logic            tout;
    logic            done;
    logic            bus_fail;
    logic            rsp_last;
    logic [31:0]     lane;
    logic [31:0]     load_val;
    logic            ext;

    assign first    = (state_q == IDLE) && i_init;
    assign beat     = first || ((state_q == ADDR) && i_init);
    assign last     = (state_q == ADDR) && i_init && (cnt_q == CW'(N-1));
    assign cin      = first ? 1'b0 : carry_q;
    assign sum      = {1'b0, i_rs1} + {1'b0, i_imm} + {{W{1'b0}}, cin};
    assign bidx     = 5'(cnt_q) * 5'(W);

    // Low address bits land in the first beats, so they are final by the last beat.
    assign is_word  = i_funct3[1];
    assign is_half  = !i_funct3[1] && i_funct3[0];
    assign misal    = is_word ? (|adr_q[1:0]) : (is_half && adr_q[0]);

    assign tout     = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT-1));
    assign done     = (state_q == BUS) && (i_wb_ack || i_wb_err || tout);
    assign bus_fail = (state_q == BUS) && (i_wb_err || (tout && !i_wb_ack));
    assign rsp_last = (state_q == RESP) && i_en && (cnt_q == CW'(N-1));

    assign ext      = !i_funct3[2];
    assign lane     = i_wb_rdt >> {adr_q[1:0], 3'b000};

    always_comb begin
        load_val = i_wb_rdt;
        if (!i_funct3[1]) begin
            if (i_funct3[0])
                load_val = {{16{ext & lane[15]}}, lane[15:0]};
            else
                load_val = {{24{ext & lane[7]}}, lane[7:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_trap) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (i_init)   state_d = ADDR;
                ADDR: if (last)     state_d = misal ? IDLE : BUS;
                BUS:  if (done)     state_d = i_cmd ? IDLE : RESP;
                RESP: if (rsp_last) state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy     = (state_q == ADDR) || (state_q == BUS);
        o_wb_cyc   = (state_q == BUS);
        o_wb_stb   = (state_q == BUS);
        o_wb_we    = i_cmd;
        o_wb_adr   = adr_q;
        o_misalign = mis_q;
        o_bus_err  = berr_q;
        o_rd       = '0;
        if ((state_q == RESP) && i_en)
            o_rd = dat_q[W-1:0];
        o_wb_sel   = 4'b0001 << adr_q[1:0];
        o_wb_dat   = {4{dat_q[7:0]}};
        if (is_word) begin
            o_wb_sel = 4'b1111;
            o_wb_dat = dat_q;
        end else if (is_half) begin
            o_wb_sel = adr_q[1] ? 4'b1100 : 4'b0011;
            o_wb_dat = {2{dat_q[15:0]}};
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        tcnt_d  = '0;
        if (beat) begin
            adr_d[bidx +: W] = sum[W-1:0];
            dat_d[bidx +: W] = i_rs2;
            carry_d          = sum[W];
            cnt_d            = cnt_q + 1'b1;
            if (first) begin
                mis_d  = 1'b0;
                berr_d = 1'b0;
            end
        end
        if (last && misal)
            mis_d = 1'b1;
        if ((state_q == BUS) && !done)
            tcnt_d = tcnt_q + 1'b1;
        // A failed load returns zero rather than stale store data.
        if (bus_fail) begin
            berr_d = 1'b1;
            if (!i_cmd)
                dat_d = '0;
        end else if ((state_q == BUS) && i_wb_ack && !i_cmd) begin
            dat_d = load_val;
        end
        if ((state_q == RESP) && i_en) begin
            dat_d = dat_q >> W;
            cnt_d = cnt_q + 1'b1;
        end
        if (i_trap) begin
            cnt_d  = '0;
            mis_d  = 1'b0;
            berr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_serv_lsu_w.sv
// tb_serv_lsu_w: randomized and directed bench for serv_lsu_w.
// Expected values come from byte-level arithmetic on whole words.
module tb_serv_lsu_w;

    localparam int W  = 2;
    localparam int N  = 32 / W;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          i_rst, i_init, i_en, i_cmd, i_trap;
    logic [2:0]    i_funct3;
    logic [W-1:0]  i_rs1, i_imm, i_rs2, o_rd;
    logic          o_busy, o_misalign, o_bus_err;
    logic [31:0]   o_wb_adr, o_wb_dat, i_wb_rdt;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we, o_wb_cyc, o_wb_stb, i_wb_ack, i_wb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serv_lsu_w #(.W(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en),
        .i_cmd(i_cmd), .i_funct3(i_funct3), .i_rs1(i_rs1), .i_imm(i_imm),
        .i_rs2(i_rs2), .i_trap(i_trap), .o_rd(o_rd), .o_busy(o_busy),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        return (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 1);
    endfunction

    function automatic logic [3:0] m_sel(input logic [31:0] a,
                                         input logic [2:0] f3);
        int s = size_of(f3);
        logic [31:0] m = ((32'd1 << s) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_dat(input logic [31:0] d,
                                          input logic [2:0] f3);
        int s = size_of(f3);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i += s)
            r |= (d & mask_of(s)) << (8 * i);
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdt,
                                           input logic [31:0] a,
                                           input logic [2:0] f3);
        int s = size_of(f3);
        logic [31:0] v = (rdt >> (8 * (a % 4))) & mask_of(s);
        if (!f3[2] && v[8*s-1])
            v |= ~mask_of(s);
        return v;
    endfunction

    // mode: 0 ack, 1 err+ack, 2 silent (timeout), 3 trap in bus, 4 reset in bus
    task automatic run(input logic cmd, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [31:0] rdt,
                       input int dly, input int mode);
        logic [31:0] a, res, expv;
        logic        mis;
        int          n;
        a   = rs1 + imm;
        mis = (a % size_of(f3)) != 0;
        i_cmd = cmd;
        i_funct3 = f3;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy_addr", {31'd0, o_busy}, 32'd1);
                chk("flag_clr", {30'd0, o_misalign, o_bus_err}, 32'd0);
            end
            i_init = 1'b1;
            i_rs1  = rs1[k*W +: W];
            i_imm  = imm[k*W +: W];
            i_rs2  = rs2[k*W +: W];
        end
        @(negedge clk);
        i_init = 1'b0;
        i_rs1 = '0;
        i_imm = '0;
        i_rs2 = '0;
        if (mis) begin
            chk("mis_flag", {31'd0, o_misalign}, 32'd1);
            chk("mis_nocyc", {31'd0, o_wb_cyc}, 32'd0);
            chk("mis_busy", {31'd0, o_busy}, 32'd0);
            repeat (2) @(negedge clk);
            chk("mis_sticky", {30'd0, o_misalign, o_wb_cyc}, 32'd2);
            return;
        end
        chk("cyc_up", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
        chk("adr", o_wb_adr, a);
        chk("sel", {28'd0, o_wb_sel}, {28'd0, m_sel(a, f3)});
        chk("we", {31'd0, o_wb_we}, {31'd0, cmd});
        if (cmd)
            chk("wdat", o_wb_dat, m_dat(rs2, f3));
        if (mode == 2) begin
            n = 0;
            while (o_wb_cyc && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("to_len", n, TO);
            chk("to_err", {30'd0, o_bus_err, o_busy}, 32'd2);
        end else begin
            repeat (dly) @(negedge clk);
            chk("cyc_hold", {31'd0, o_wb_cyc}, 32'd1);
            chk("adr_hold", o_wb_adr, a);
            if (mode == 3) begin
                i_trap = 1'b1;
                @(negedge clk);
                i_trap = 1'b0;
                chk("trap", {29'd0, o_wb_cyc, o_busy, o_bus_err}, 32'd0);
                return;
            end
            if (mode == 4) begin
                i_rst = 1'b1;
                i_wb_ack = 1'b1;
                @(negedge clk);
                i_rst = 1'b0;
                i_wb_ack = 1'b0;
                chk("rst_ctl", {29'd0, o_wb_cyc, o_busy, o_bus_err}, 32'd0);
                chk("rst_adr", o_wb_adr, 32'd0);
                return;
            end
            i_wb_ack = 1'b1;
            i_wb_err = (mode == 1);
            i_wb_rdt = rdt;
            @(negedge clk);
            i_wb_ack = 1'b0;
            i_wb_err = 1'b0;
            i_wb_rdt = $urandom;
            chk("cyc_down", {30'd0, o_wb_cyc, o_busy}, 32'd0);
            chk("berr", {31'd0, o_bus_err}, {31'd0, mode == 1});
        end
        if (cmd) begin
            i_en = 1'b1;
            #1;
            chk("rd_store", {{(32-W){1'b0}}, o_rd}, 32'd0);
            @(negedge clk);
            i_en = 1'b0;
            return;
        end
        res = 0;
        for (int k = 0; k < N; k++) begin
            i_en = 1'b1;
            #1;
            res[k*W +: W] = o_rd;
            @(negedge clk);
        end
        i_en = 1'b0;
        expv = (mode == 0) ? m_load(rdt, a, f3) : 32'd0;
        chk("load", res, expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] r1, im;
        int          r;
        i_rst = 1'b1; i_init = 1'b0; i_en = 1'b0; i_cmd = 1'b0;
        i_trap = 1'b0; i_funct3 = 3'b010; i_rs1 = '0; i_imm = '0;
        i_rs2 = '0; i_wb_rdt = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {28'd0, o_wb_cyc, o_busy, o_misalign, o_bus_err},
            32'd0);
        chk("rst_adr", o_wb_adr, 32'd0);
        i_en = 1'b1;
        #1;
        chk("rst_rd", {{(32-W){1'b0}}, o_rd}, 32'd0);
        i_en = 1'b0;
        i_rst = 1'b0;

        run(0, 3'b010, 32'h1000, 32'd4, 32'h0, 32'hDEADBEEF, 3, 0);
        run(0, 3'b000, 32'h2000, 32'd3, 32'h0, 32'h80FF0000, 1, 0);
        run(0, 3'b100, 32'h2000, 32'd3, 32'h0, 32'h80FF0000, 0, 0);
        run(1, 3'b001, 32'h10, 32'd2, 32'h1234ABCD, 32'h0, 0, 0);
        run(0, 3'b010, 32'h1000, 32'd2, 32'h0, 32'h0, 0, 0);
        run(0, 3'b001, 32'h1000, 32'd3, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        i_trap = 1'b1;
        @(negedge clk);
        i_trap = 1'b0;
        chk("trap_clr", {31'd0, o_misalign}, 32'd0);
        run(0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0, 0, 2);
        run(1, 3'b010, 32'h300, 32'h4, 32'hCAFEF00D, 32'h0, 0, 2);
        run(0, 3'b010, 32'h400, 32'h8, 32'h0, 32'h55AA55AA, 2, 1);
        run(0, 3'b101, 32'h7FFF_FFFE, 32'h4, 32'h0, 32'hFFFF1234, 0, 0);
        run(1, 3'b000, 32'h500, 32'h1, 32'h11, 32'h0, 2, 3);
        run(0, 3'b010, 32'h600, 32'h0, 32'h0, 32'h0, 1, 4);

        for (int t = 0; t < 40; t++) begin
            r1 = $urandom;
            im = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                r1 &= ~32'd3;
                im &= ~32'd3;
            end
            r = $urandom_range(9, 0);
            run(1'($urandom_range(1, 0)), f3s[$urandom_range(4, 0)], r1, im,
                $urandom, $urandom, $urandom_range(4, 0),
                (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 3 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
